vga_text_buffer: RTL and testbench

Parametrised memory-mapped character buffer between the CPU data bus and the VGA text renderer. It holds `CHARS` 8-bit character codes and accepts CPU writes to a decoded address window, with direct-indexed and auto-incrementing (cursor) modes. A hardware clear sequencer fills the buffer, and a registered read port serves both the CPU and the renderer. It is the generalised successor of the fixed 36-character DMA buffer in the VGA path.

---
 rtl/vga_text_buffer_if.sv | 27 ++
 rtl/vga_text_buffer.sv | 137 +++++++++++++
 tb/tb_vga_text_buffer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/vga_text_buffer_if.sv
// CPU/renderer bus bundle for vga_text_buffer: write port, registered read port,
// renderer character port and clear-busy status.
interface vga_text_buffer_if #(
  parameter int IDX_W = 6
);
  logic             wr_en;
  logic [63:0]      wr_addr;
  logic [63:0]      wr_data;
  logic             wr_ready;
  logic             rd_en;
  logic [63:0]      rd_addr;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic [IDX_W-1:0] char_idx;
  logic [7:0]       char_out;
  logic             busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, char_idx,
    input  wr_ready, rd_data, rd_valid, char_out, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, char_idx,
    output wr_ready, rd_data, rd_valid, char_out, busy
  );
endinterface

// File: rtl/vga_text_buffer.sv
// Memory-mapped VGA text character buffer: direct/cursor-stream writes, hardware clear,
// registered CPU and renderer reads. Optional macro VGA_TEXT_DIGIT_ASCII_EN maps 0..9 to ASCII.
module vga_text_buffer #(
  parameter int          CHARS     = 36,
  parameter logic [63:0] ADDR_BASE = 64'h0B00_0000,
  parameter int          ADDR_SPAN = 256,
  parameter logic [7:0]  FILL_CHAR = 8'h00,
  parameter int          IDX_W     = $clog2(CHARS)
)(
  input logic              clk,
  input logic              aresetn,
  vga_text_buffer_if.slave bus
);

  localparam logic [63:0]      OFF_CURSOR = 64'hF0;
  localparam logic [63:0]      OFF_STREAM = 64'hF8;
  localparam logic [63:0]      OFF_CTRL   = 64'hFC;
  localparam logic [63:0]      ADDR_END   = ADDR_BASE + 64'(ADDR_SPAN);
  localparam logic [63:0]      DEPTH      = 64'(CHARS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(CHARS - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_clr_ptr;
  logic [IDX_W-1:0] r_cursor;
  logic [7:0]       r_buf [CHARS];
  logic [7:0]       r_rd_data;
  logic             r_rd_valid;
  logic [7:0]       r_char_out;

  logic             w_busy;
  logic             w_wr_hit, w_wr_acc;
  logic [63:0]      w_wr_off;
  logic             w_wr_buf, w_wr_cur, w_wr_str, w_wr_ctl;
  logic             w_buf_we;
  logic [IDX_W-1:0] w_buf_idx;
  logic [7:0]       w_store;
  logic             w_rd_hit;
  logic [63:0]      w_rd_off;
  logic [7:0]       w_rd_val;

  assign w_busy       = (r_state == S_CLEAR);
  assign bus.busy     = w_busy;
  assign bus.wr_ready = (r_state == S_IDLE);

  // Full-width decode so addresses outside the window never alias into it
  assign w_wr_hit = (bus.wr_addr >= ADDR_BASE) && (bus.wr_addr < ADDR_END);
  assign w_wr_off = bus.wr_addr - ADDR_BASE;
  assign w_wr_acc = bus.wr_en && bus.wr_ready && w_wr_hit;
  assign w_wr_buf = w_wr_acc && (w_wr_off < DEPTH);
  assign w_wr_cur = w_wr_acc && (w_wr_off == OFF_CURSOR);
  assign w_wr_str = w_wr_acc && (w_wr_off == OFF_STREAM);
  assign w_wr_ctl = w_wr_acc && (w_wr_off == OFF_CTRL);

  assign w_buf_we  = w_wr_buf || w_wr_str;
  assign w_buf_idx = w_wr_str ? r_cursor : w_wr_off[IDX_W-1:0];

`ifdef VGA_TEXT_DIGIT_ASCII_EN
  assign w_store = (bus.wr_data[7:0] < 8'd10) ? (bus.wr_data[7:0] + 8'h30) : bus.wr_data[7:0];
`else
  assign w_store = bus.wr_data[7:0];
`endif

  // Clear sequencer; also owns the cursor since clear completion resets it
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= S_IDLE;
      r_clr_ptr <= '0;
      r_cursor  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr_ctl && bus.wr_data[0]) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
          end else if (w_wr_cur) begin
            r_cursor <= (bus.wr_data < DEPTH) ? bus.wr_data[IDX_W-1:0] : '0;
          end else if (w_wr_str) begin
            r_cursor <= (r_cursor == LAST_IDX) ? '0 : r_cursor + 1'b1;
          end
        end
        S_CLEAR: begin
          if (r_clr_ptr == LAST_IDX) begin
            r_state   <= S_IDLE;
            r_clr_ptr <= '0;
            r_cursor  <= '0;
          end else begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // CPU writes cannot collide with fill writes: wr_ready is low during clear
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < CHARS; i++) r_buf[i] <= 8'h00;
    end else if (w_busy) begin
      r_buf[r_clr_ptr] <= FILL_CHAR;
    end else if (w_buf_we) begin
      r_buf[w_buf_idx] <= w_store;
    end
  end

  assign w_rd_hit = (bus.rd_addr >= ADDR_BASE) && (bus.rd_addr < ADDR_END);
  assign w_rd_off = bus.rd_addr - ADDR_BASE;

  always_comb begin
    w_rd_val = 8'h00;
    if (w_rd_hit) begin
      if (w_rd_off < DEPTH)            w_rd_val = r_buf[w_rd_off[IDX_W-1:0]];
      else if (w_rd_off == OFF_CURSOR) w_rd_val = 8'(r_cursor);
      else if (w_rd_off == OFF_CTRL)   w_rd_val = {7'b0, w_busy};
    end
  end

  // Registered reads sample r_buf before this edge's write lands (read-before-write)
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_rd_data  <= 8'h00;
      r_rd_valid <= 1'b0;
      r_char_out <= 8'h00;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) r_rd_data <= w_rd_val;
      r_char_out <= (32'(bus.char_idx) < CHARS) ? r_buf[bus.char_idx] : 8'h00;
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.char_out = r_char_out;

endmodule

// File: tb/tb_vga_text_buffer.sv
// Directed self-checking bench for vga_text_buffer with hand-computed expectations.
module tb_vga_text_buffer;
  localparam int          CHARS = 36;
  localparam logic [63:0] BASE  = 64'h0B00_0000;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  vga_text_buffer_if #(.IDX_W(6)) bus();

  vga_text_buffer #(
    .CHARS(CHARS), .ADDR_BASE(BASE), .ADDR_SPAN(256), .FILL_CHAR(8'h00)
  ) dut (
    .clk(clk), .aresetn(aresetn), .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [63:0] a, input logic [63:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [63:0] a, output logic [7:0] d, output logic v);
    bus.rd_en = 1'b1; bus.rd_addr = a;
    step();
    bus.rd_en = 1'b0;
    d = bus.rd_data; v = bus.rd_valid;
  endtask

  task automatic rd_chk(input string tag, input logic [63:0] off, input logic [7:0] exp);
    logic [7:0] d;
    logic v;
    bus_rd(BASE + off, d, v);
    chk({tag, ".data"}, 64'(d), 64'(exp));
    chk({tag, ".valid"}, 64'(v), 64'd1);
  endtask

  logic [7:0] exp_d7, exp_d9;
  int cnt;
  logic [7:0] d;
  logic v;

  initial begin
`ifdef VGA_TEXT_DIGIT_ASCII_EN
    exp_d7 = 8'h37; exp_d9 = 8'h39;
`else
    exp_d7 = 8'h07; exp_d9 = 8'h09;
`endif
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.rd_en = 0; bus.rd_addr = 0; bus.char_idx = 0;
    step();
    chk("rst.busy", 64'(bus.busy), 0);
    chk("rst.wr_ready", 64'(bus.wr_ready), 1);
    chk("rst.rd_valid", 64'(bus.rd_valid), 0);
    chk("rst.rd_data", 64'(bus.rd_data), 0);
    chk("rst.char_out", 64'(bus.char_out), 0);
    step();
    aresetn = 1'b1;
    step();

    for (int i = 0; i < CHARS; i++) rd_chk($sformatf("rst_rd%0d", i), 64'(i), 8'h00);
    step();
    chk("rd_valid_drop", 64'(bus.rd_valid), 0);

    // Basic write then read; renderer port
    bus_wr(BASE + 1, 64'h48);
    rd_chk("wr_rd1", 1, 8'h48);
    bus.char_idx = 1;
    step();
    chk("char1", 64'(bus.char_out), 64'h48);

    // Digit mapping (config dependent) and its boundaries
    bus_wr(BASE + 2, 64'h07);
    rd_chk("digit7", 2, exp_d7);
    bus_wr(BASE + 3, 64'h41);
    rd_chk("ascii41", 3, 8'h41);
    bus_wr(BASE + 4, 64'h09);
    rd_chk("digit9", 4, exp_d9);
    bus_wr(BASE + 5, 64'h0A);
    rd_chk("digitA", 5, 8'h0A);

    // Cursor stream with wrap
    bus_wr(BASE + 64'hF0, 64'd34);
    bus_wr(BASE + 64'hF8, 64'h41);
    bus_wr(BASE + 64'hF8, 64'h42);
    bus_wr(BASE + 64'hF8, 64'h43);
    rd_chk("str34", 34, 8'h41);
    rd_chk("str35", 35, 8'h42);
    rd_chk("str0", 0, 8'h43);
    rd_chk("cursor1", 64'hF0, 8'd1);
    bus_wr(BASE + 64'hF0, 64'd40);
    rd_chk("cursor_oor", 64'hF0, 8'd0);
    bus_wr(BASE + 64'hF0, 64'd35);
    rd_chk("cursor35", 64'hF0, 8'd35);

    // Simultaneous write and read of the same index returns the old value
    bus_wr(BASE + 7, 64'h22);
    bus.char_idx = 7;
    bus.wr_en = 1; bus.wr_addr = BASE + 7; bus.wr_data = 64'h33;
    bus.rd_en = 1; bus.rd_addr = BASE + 7;
    step();
    bus.wr_en = 0; bus.rd_en = 0;
    chk("rbw.rd", 64'(bus.rd_data), 64'h22);
    chk("rbw.char", 64'(bus.char_out), 64'h22);
    step();
    chk("rbw.char_new", 64'(bus.char_out), 64'h33);
    rd_chk("rbw.rd_new", 7, 8'h33);

    // Renderer index past depth
    bus.char_idx = 6'd36;
    step();
    chk("char36", 64'(bus.char_out), 0);
    bus.char_idx = 6'd63;
    step();
    chk("char63", 64'(bus.char_out), 0);
    bus.char_idx = 0;

    // Clear: busy for exactly CHARS cycles; a held write to index 0 is dropped
    bus_wr(BASE + 64'hFC, 64'h3);
    chk("clr.busy", 64'(bus.busy), 1);
    chk("clr.wr_ready", 64'(bus.wr_ready), 0);
    bus.wr_en = 1; bus.wr_addr = BASE; bus.wr_data = 64'h77;
    bus_rd(BASE + 64'hFC, d, v);
    chk("clr.ctrl_rd", 64'(d), 1);
    cnt = 1;
    while (bus.busy && cnt < 100) begin
      cnt++;
      step();
    end
    bus.wr_en = 0;
    chk("clr.cycles", 64'(cnt), 64'd36);
    chk("clr.ready_back", 64'(bus.wr_ready), 1);
    rd_chk("clr.cursor", 64'hF0, 8'd0);
    for (int i = 0; i < CHARS; i++) rd_chk($sformatf("clr_rd%0d", i), 64'(i), 8'h00);

    // Misses and unmapped offsets leave the buffer untouched
    bus_wr(BASE + 1, 64'h5A);
    bus_wr(BASE + 64'h100, 64'h99);
    bus_wr(64'h0AFF_FFFF, 64'h98);
    bus_wr(BASE + 64'hE0, 64'h97);
    rd_chk("miss.0", 0, 8'h00);
    rd_chk("miss.1", 1, 8'h5A);
    rd_chk("miss.35", 35, 8'h00);
    rd_chk("miss.E0", 64'hE0, 8'h00);
    bus_rd(BASE + 64'h100, d, v);
    chk("miss.rd_out", 64'(d), 0);

    // Reset in the middle of a clear
    bus_wr(BASE + 30, 64'h5A);
    rd_chk("mid.pre30", 30, 8'h5A);
    bus.char_idx = 30;
    bus_wr(BASE + 64'hFC, 64'h1);
    repeat (9) step();
    chk("mid.busy", 64'(bus.busy), 1);
    chk("mid.char_pre", 64'(bus.char_out), 64'h5A);
    aresetn = 1'b0;
    #2;
    chk("mid.rst_busy", 64'(bus.busy), 0);
    chk("mid.rst_ready", 64'(bus.wr_ready), 1);
    chk("mid.rst_rd_data", 64'(bus.rd_data), 0);
    chk("mid.rst_char", 64'(bus.char_out), 0);
    step();
    aresetn = 1'b1;
    step();
    chk("mid.busy_after", 64'(bus.busy), 0);
    rd_chk("mid.30", 30, 8'h00);
    rd_chk("mid.1", 1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
